// File: rtl/serial_add_sequencer.sv
// Bit-serial N-bit adder: one time-shared full-adder cell (two half adders + OR)
// walks the operands LSB-first under a start/busy/done handshake.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_sequencer #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           busy_next;
    logic           done_next;

    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic [N-2:0]   sr;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic           p;
    logic           g1;
    logic           s;
    logic           g2;
    logic           carry_next;
    logic [N-1:0]   sr_full;

    logic           accept;
    logic           last_bit;
    logic           state_bad;

    half_adder ha1 (.x(sa[0]), .y(sb[0]), .s(p), .c(g1));
    half_adder ha2 (.x(p),     .y(carry), .s(s), .c(g2));

    assign carry_next = g1 | g2;
    // Previously produced bits plus this cycle's bit, already in final LSB-first order.
    assign sr_full    = {s, sr};

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_bit  = (state == RUN) && (cnt == CW'(N - 1));
    assign state_bad = !((state == IDLE) || (state == RUN) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst || state_bad) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
            if (accept) begin
                sa    <= a;
                sb    <= b;
                carry <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN) begin
                carry <= carry_next;
                sr    <= sr_full[N-1:1];
                sa    <= {1'b0, sa[N-1:1]};
                sb    <= {1'b0, sb[N-1:1]};
                if (last_bit) begin
                    sum  <= sr_full;
                    cout <= carry_next;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered, so they are decoded from the state being entered.
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and exhaustive self-checking bench for serial_add_sequencer (N=4).

module tb_serial_add_sequencer;
    localparam int N  = 4;
    localparam int CW = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int n_vec;
    int n_miss;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[7];

    serial_add_sequencer #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle and wait (bounded) for done; reports latency,
    // busy cycles, and whether sum/cout moved before done.
    task automatic applyStimulus(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                 output int lat, output int busy_cnt, output logic unstable);
        logic [N:0] held;
        @(negedge clk);
        held     = {cout, sum};
        a        = ta;
        b        = tb;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        unstable = ({cout, sum} !== held);
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (!done && ({cout, sum} !== held)) unstable = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        int   bc;
        logic unst;
        int   done_cnt;
        logic [N:0] want;

        n_vec  = 0;
        n_miss = 0;
        vecs[0] = '{a: 4'd0,  b: 4'd0,  exp_sum: 4'b0000, exp_cout: 1'b0};
        vecs[1] = '{a: 4'd5,  b: 4'd3,  exp_sum: 4'b1000, exp_cout: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd1,  exp_sum: 4'b0000, exp_cout: 1'b1};
        vecs[3] = '{a: 4'd15, b: 4'd15, exp_sum: 4'b1110, exp_cout: 1'b1};
        vecs[4] = '{a: 4'd10, b: 4'd5,  exp_sum: 4'b1111, exp_cout: 1'b0};
        vecs[5] = '{a: 4'd6,  b: 4'd6,  exp_sum: 4'b1100, exp_cout: 1'b0};
        vecs[6] = '{a: 4'd8,  b: 4'd8,  exp_sum: 4'b0000, exp_cout: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum",  32'(sum),  32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat, bc, unst);
            checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'd5);
            checkOutput($sformatf("v%0d busy cycles", i), 32'(bc), 32'd4);
            checkOutput($sformatf("v%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            checkOutput($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            checkOutput($sformatf("v%0d stable", i), 32'(unst), 32'd0);
        end

        // Start during RUN must be ignored.
        @(negedge clk);
        a = 4'd2; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                done_cnt++;
                checkOutput("ignore sum",  32'(sum),  32'h3);
                checkOutput("ignore cout", 32'(cout), 32'd0);
            end
            @(negedge clk);
        end
        checkOutput("ignore done pulses", 32'(done_cnt), 32'd1);

        // Back-to-back with start held high.
        @(negedge clk);
        a = 4'd7; b = 4'd8; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 12);
        checkOutput("b2b first latency", 32'(lat), 32'd5);
        checkOutput("b2b first sum",  32'(sum),  32'hF);
        checkOutput("b2b first cout", 32'(cout), 32'd0);
        a = 4'd9; b = 4'd6;
        @(negedge clk);
        checkOutput("b2b no bubble busy", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput("b2b done spacing", 32'(lat), 32'd5);
        checkOutput("b2b second sum",  32'(sum),  32'hF);
        checkOutput("b2b second cout", 32'(cout), 32'd0);
        @(negedge clk);
        checkOutput("b2b back to idle", 32'(busy | done), 32'd0);

        // Reset during RUN.
        @(negedge clk);
        a = 4'd12; b = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst sum",  32'(sum),  32'd0);
        checkOutput("midrst cout", 32'(cout), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        checkOutput("midrst stays idle", 32'(done_cnt), 32'd0);

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus(4'(i), 4'(j), lat, bc, unst);
                want = 5'(i + j);
                checkOutput($sformatf("exh %0d+%0d", i, j), 32'({cout, sum}), 32'(want));
                if (unst || lat != 5)
                    checkOutput($sformatf("exh %0d+%0d timing/stable", i, j), 32'({unst, 8'(lat)}), 32'h005);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial N-bit adder controller; a single full-adder cell is time-shared across all bit positions.
- The full-adder cell is two half-adder instances plus an OR gate.
- Operands are captured on a start request and fed LSB-first through the shared cell, one bit per clock, with the carry held in a register.
- The block presents a start/busy/done handshake to the surrounding lab datapath and holds the result until the next operation.

Parameters:
N, 4, operand and sum width in bits (N >= 2)
CW, 3, bit-counter width; must satisfy 2**CW >= N

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset; one clock; sampled on rising edge of clk
start  input  1  request to begin an addition; sampled only in IDLE or DONE
a  input  N  operand A; captured on an accepted start
b  input  N  operand B; captured on an accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/cout are valid from this cycle on
sum  output  N  registered sum, A+B mod 2**N
cout  output  1  registered carry-out of bit N-1

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything, in any state including mid-RUN:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0
  - carry register=0, bit counter=0, operand shift registers=0
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 -> capture a,b into shift registers sa,sb; carry=0; counter=0; go to RUN.
  - sum/cout retain their previous values.
  - start=0 -> stay in IDLE.
- RUN (busy=1), each cycle:
  - Half adder 1: p=sa[0]^sb[0], g1=sa[0]&sb[0].
  - Half adder 2: s=p^carry, g2=p&carry.
  - carry <= g1|g2.
  - Result shift register: sr <= {s, sr[N-1:1]}.
  - sa,sb shift right one bit, zero fill.
  - counter increments.
  - When counter==N-1, this cycle's bit is the MSB: next state DONE; sum <= {s, sr[N-1:1]}; cout <= g1|g2.
  - start is ignored in RUN; operands are not re-captured.
- DONE: done=1 for exactly this cycle; busy=0.
  - start=1 -> accept as in IDLE (back-to-back operation, no bubble); go to RUN.
  - start=0 -> go to IDLE.
- Latency: start sampled at edge k -> RUN for edges k+1..k+N -> done=1 during the cycle after edge k+N. Total N+1 cycles from start to done.
- Throughput: one addition per N+1 cycles with start held high.
- sum/cout change only on the edge entering DONE, or on reset.
- Changing a,b after an accepted start has no effect on the operation in progress.
- Arithmetic: unsigned; {cout,sum} == a+b exactly (N+1 bits).
- Counter is compared, never allowed to wrap past N-1 within RUN.
- Illegal/unused state encoding -> IDLE on the next edge, with outputs cleared as on reset.

Test Plan:
- N=4, reset, then a=0, b=0, start pulse -> busy high 4 cycles, done pulse on 5th cycle after start edge, sum=0000, cout=0.
- a=5, b=3 -> sum=1000, cout=0. a=15, b=1 -> sum=0000, cout=1. a=15, b=15 -> sum=1110, cout=1.
- Start during RUN: a=2, b=1 accepted, then at the 2nd RUN cycle apply start=1 with a=9, b=9 -> ignored; result sum=0011, cout=0, exactly one done pulse.
- Back-to-back: start held high with a=7, b=8, then a=9, b=6 presented in the DONE cycle:
  - done pulses 5 cycles apart
  - first result sum=1111, cout=0
  - second result sum=1111, cout=0, with no idle cycle between them
- Reset mid-run: after accepted start with a=12, b=12, assert rst in the 3rd RUN cycle -> next edge busy=0, done=0, sum=0, cout=0, state IDLE; no done pulse follows.
- Exhaustive: all 256 (a,b) pairs, N=4, sequentially -> every {cout,sum} equals a+b; sum/cout stable between done pulses.
